// File: rtl/hdmi_fb_pkg.sv
// Shared types for the HDMI frame-buffer arbiter: engine states, grant encoding
// and the bank-base helper used when FB_DOUBLE_BUFFER_EN is defined.
package hdmi_fb_pkg;

  typedef enum logic [1:0] {W_P0 = 2'd0, W_P1 = 2'd1, W_HOLD = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DONE = 2'd2} rd_state_t;
  typedef enum logic [1:0] {G_NONE = 2'd0, G_RD = 2'd1, G_WR = 2'd2} grant_t;

  localparam int WORD_PIX = 2;

  // Bank 1 lives in the upper half of the word address space.
  function automatic logic [31:0] bank_base(input logic bank, input int addr_w);
    if (bank) bank_base = 32'd1 << (addr_w - 1);
    else      bank_base = 32'd0;
  endfunction

endpackage

// File: rtl/fb_rd_fifo.sv
// Read-prefetch FIFO for RAM words; flush empties it in one cycle and wins over push/pop.
module fb_rd_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk_low,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  logic [W-1:0] mem_r [DEPTH];
  logic [PW:0]  wp_r;
  logic [PW:0]  rp_r;

  // word storage
  always_ff @(posedge clk_low) begin
    if (push && !flush) mem_r[wp_r[PW-1:0]] <= din;
  end

  // pointers; the extra MSB separates full from empty
  always_ff @(posedge clk_low) begin
    if (reset || flush) begin
      wp_r <= {(PW + 1){1'b0}};
      rp_r <= {(PW + 1){1'b0}};
    end else begin
      if (push) wp_r <= wp_r + PTR_ONE;
      if (pop)  rp_r <= rp_r + PTR_ONE;
    end
  end

  assign dout  = mem_r[rp_r[PW-1:0]];
  assign level = wp_r - rp_r;
  assign empty = (wp_r == rp_r);

endmodule

// File: rtl/hdmi_fb_arbiter.sv
// Single-port frame-buffer arbiter between camera writes and HDMI prefetch reads.
// Define FB_DOUBLE_BUFFER_EN for two banks selected by mem_addr[ADDR_W-1].
module hdmi_fb_arbiter
  import hdmi_fb_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int FRAME_PIX  = 307200,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 8,
  parameter int RD_THRESH  = 4
) (
  input  logic                  clk_low,
  input  logic                  reset,
  input  logic                  cam_valid,
  input  logic [PIX_W-1:0]      cam_data,
  input  logic                  cam_sof,
  output logic                  cam_ready,
  input  logic                  disp_sof,
  input  logic                  disp_req,
  output logic [PIX_W-1:0]      disp_data,
  output logic                  underrun,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [2*PIX_W-1:0]    mem_wdata,
  input  logic [2*PIX_W-1:0]    mem_rdata
);
  localparam int WORD_W = WORD_PIX * PIX_W;
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PEND_W = LVL_W + 1;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_PIX / 2 - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [PEND_W-1:0] THRESH_P  = PEND_W'(RD_THRESH);
  localparam logic [PEND_W-1:0] DEPTH_P   = PEND_W'(FIFO_DEPTH);

  wr_state_t           wr_state_r, wr_state_s;
  rd_state_t           rd_state_r, rd_state_s;
  grant_t              grant_r, grant_s;
  logic [PIX_W-1:0]    pix0_r;
  logic [WORD_W-1:0]   word_r;
  logic [ADDR_W-1:0]   wr_cnt_r, rd_cnt_r, rd_cnt_s;
  logic [ADDR_W-1:0]   wr_base_s, rd_base_s;
  logic                cam_ready_r, cam_take_s;
  logic                ret_r, rd_ok_s, pop_s, phase_r;
  logic [PEND_W-1:0]   pending_s;
  logic [PIX_W-1:0]    disp_data_r;
  logic                underrun_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic                mem_we_r;
  logic [WORD_W-1:0]   mem_wdata_r;
  logic [WORD_W-1:0]   fifo_dout_s;
  logic [LVL_W-1:0]    fifo_level_s;
  logic                fifo_empty_s;

  assign cam_take_s = cam_valid && cam_ready_r;

`ifdef FB_DOUBLE_BUFFER_EN
  logic wr_bank_r, rd_bank_r, done_bank_r, done_new_r, frame_done_s;
  assign frame_done_s = (grant_s == G_WR) && (wr_cnt_r == LAST_WORD);

  // bank bookkeeping: writer avoids the displayed bank, reader follows the latest complete one
  always_ff @(posedge clk_low) begin
    if (reset) begin
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      done_bank_r <= 1'b0;
      done_new_r  <= 1'b0;
    end else begin
      if (cam_take_s && cam_sof) wr_bank_r <= ~rd_bank_r;
      if (disp_sof && done_new_r) begin
        rd_bank_r  <= done_bank_r;
        done_new_r <= 1'b0;
      end
      if (frame_done_s) begin
        done_bank_r <= wr_bank_r;
        done_new_r  <= 1'b1;
      end
    end
  end
  assign wr_base_s = ADDR_W'(bank_base(wr_bank_r, ADDR_W));
  assign rd_base_s = ADDR_W'(bank_base(rd_bank_r, ADDR_W));
`else
  assign wr_base_s = ADDR_ZERO;
  assign rd_base_s = ADDR_ZERO;
`endif

  // arbitration; reads are withheld on disp_sof so no stale-frame read gets issued
  always_comb begin
    pending_s = PEND_W'(fifo_level_s) + PEND_W'(grant_r == G_RD) + PEND_W'(ret_r);
    rd_ok_s   = (rd_state_r == R_FETCH) && !disp_sof;
    grant_s   = G_NONE;
    if (rd_ok_s && (pending_s < THRESH_P))     grant_s = G_RD;
    else if (wr_state_r == W_HOLD)             grant_s = G_WR;
    else if (rd_ok_s && (pending_s < DEPTH_P)) grant_s = G_RD;
    else                                       grant_s = G_NONE;
  end

  // write engine next state
  always_comb begin
    wr_state_s = wr_state_r;
    if (cam_take_s && cam_sof) begin
      wr_state_s = W_P1;
    end else begin
      case (wr_state_r)
        W_P0:    wr_state_s = cam_take_s ? W_P1 : W_P0;
        W_P1:    wr_state_s = cam_take_s ? W_HOLD : W_P1;
        W_HOLD:  wr_state_s = (grant_s == G_WR) ? W_P0 : W_HOLD;
        default: wr_state_s = W_P0;
      endcase
    end
  end

  // write engine registers and pixel pairing
  always_ff @(posedge clk_low) begin
    if (reset) begin
      wr_state_r  <= W_P0;
      cam_ready_r <= 1'b0;
      pix0_r      <= {PIX_W{1'b0}};
      word_r      <= {WORD_W{1'b0}};
      wr_cnt_r    <= ADDR_ZERO;
    end else begin
      wr_state_r  <= wr_state_s;
      cam_ready_r <= (wr_state_s != W_HOLD);
      if (cam_take_s && (cam_sof || (wr_state_r == W_P0))) pix0_r <= cam_data;
      if (cam_take_s && !cam_sof && (wr_state_r == W_P1)) word_r <= {cam_data, pix0_r};
      if (cam_take_s && cam_sof)  wr_cnt_r <= ADDR_ZERO;
      else if (grant_s == G_WR)   wr_cnt_r <= (wr_cnt_r == LAST_WORD) ? ADDR_ZERO : wr_cnt_r + ADDR_ONE;
    end
  end

  // read engine next state
  always_comb begin
    rd_state_s = rd_state_r;
    rd_cnt_s   = rd_cnt_r;
    if (disp_sof) begin
      rd_state_s = R_FETCH;
      rd_cnt_s   = ADDR_ZERO;
    end else if (grant_s == G_RD) begin
      rd_cnt_s   = rd_cnt_r + ADDR_ONE;
      rd_state_s = (rd_cnt_r == LAST_WORD) ? R_DONE : R_FETCH;
    end else begin
      rd_state_s = rd_state_r;
    end
  end

  // read engine registers
  always_ff @(posedge clk_low) begin
    if (reset) begin
      rd_state_r <= R_IDLE;
      rd_cnt_r   <= ADDR_ZERO;
    end else begin
      rd_state_r <= rd_state_s;
      rd_cnt_r   <= rd_cnt_s;
    end
  end

  // RAM port; a read granted now returns two cycles later and is dropped across disp_sof
  always_ff @(posedge clk_low) begin
    if (reset) begin
      grant_r     <= G_NONE;
      ret_r       <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= ADDR_ZERO;
      mem_wdata_r <= {WORD_W{1'b0}};
    end else begin
      grant_r  <= grant_s;
      ret_r    <= (grant_r == G_RD) && !disp_sof;
      mem_we_r <= (grant_s == G_WR);
      case (grant_s)
        G_RD: mem_addr_r <= rd_base_s + rd_cnt_r;
        G_WR: begin
          mem_addr_r  <= wr_base_s + wr_cnt_r;
          mem_wdata_r <= word_r;
        end
        default: mem_addr_r <= mem_addr_r;
      endcase
    end
  end

  assign pop_s = disp_req && !disp_sof && !fifo_empty_s && phase_r;

  fb_rd_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_low (clk_low),
    .reset   (reset),
    .flush   (disp_sof),
    .push    (ret_r),
    .din     (mem_rdata),
    .pop     (pop_s),
    .dout    (fifo_dout_s),
    .level   (fifo_level_s),
    .empty   (fifo_empty_s)
  );

  // display pixel output, pixel phase and sticky underrun
  always_ff @(posedge clk_low) begin
    if (reset || disp_sof) begin
      phase_r     <= 1'b0;
      disp_data_r <= {PIX_W{1'b0}};
      underrun_r  <= 1'b0;
    end else if (disp_req) begin
      if (fifo_empty_s) begin
        disp_data_r <= {PIX_W{1'b0}};
        underrun_r  <= 1'b1;
      end else begin
        disp_data_r <= phase_r ? fifo_dout_s[WORD_W-1:PIX_W] : fifo_dout_s[PIX_W-1:0];
        phase_r     <= ~phase_r;
      end
    end
  end

  assign cam_ready = cam_ready_r;
  assign disp_data = disp_data_r;
  assign underrun  = underrun_r;
  assign mem_addr  = mem_addr_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_hdmi_fb_arbiter.sv
// Directed self-checking bench for hdmi_fb_arbiter with a 1-cycle RAM model.
module tb_hdmi_fb_arbiter;
  localparam int PIX_W = 8, FRAME_PIX = 16, ADDR_W = 4, FIFO_DEPTH = 4, RD_THRESH = 2;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam logic [3:0] WB = 4'd8;
`else
  localparam logic [3:0] WB = 4'd0;
`endif

  logic        clk_low = 1'b0;
  logic        reset = 1'b1;
  logic        cam_valid = 1'b0, cam_sof = 1'b0, cam_ready;
  logic [7:0]  cam_data = 8'h00;
  logic        disp_sof = 1'b0, disp_req = 1'b0, underrun;
  logic [7:0]  disp_data;
  logic [3:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata, mem_rdata;

  logic        pre_we = 1'b0, log_clr = 1'b0;
  logic [3:0]  pre_addr = 4'd0;
  logic [15:0] pre_data = 16'h0000;
  logic [15:0] ram [16];
  logic [3:0]  log_addr [$];
  logic [15:0] log_data [$];

  int checks = 0;
  int failures = 0;

  always #5 clk_low = ~clk_low;

  hdmi_fb_arbiter #(.PIX_W(PIX_W), .FRAME_PIX(FRAME_PIX), .ADDR_W(ADDR_W),
                    .FIFO_DEPTH(FIFO_DEPTH), .RD_THRESH(RD_THRESH)) dut (
    .clk_low(clk_low), .reset(reset), .cam_valid(cam_valid), .cam_data(cam_data),
    .cam_sof(cam_sof), .cam_ready(cam_ready), .disp_sof(disp_sof), .disp_req(disp_req),
    .disp_data(disp_data), .underrun(underrun), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  // RAM model with write log
  always @(posedge clk_low) begin
    mem_rdata <= ram[mem_addr];
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    if (log_clr) begin
      log_addr.delete();
      log_data.delete();
    end else if (mem_we) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic tick;
    @(posedge clk_low);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; cam_valid = 1'b0; cam_sof = 1'b0; disp_sof = 1'b0; disp_req = 1'b0;
    log_clr = 1'b1;
    tick; tick;
    log_clr = 1'b0; reset = 1'b0;
    tick;
  endtask

  task automatic preload(input logic [3:0] base, input logic [7:0] first);
    for (int k = 0; k < 8; k++) begin
      pre_we = 1'b1; pre_addr = base + 4'(k);
      pre_data = {first + 8'(2 * k + 1), first + 8'(2 * k)};
      tick;
    end
    pre_we = 1'b0;
  endtask

  task automatic cam_frame(input logic [7:0] first, input int npix, output int lows);
    int i, guard;
    i = 0; lows = 0; guard = 0;
    while (i < npix) begin
      cam_valid = 1'b1; cam_data = first + 8'(i); cam_sof = (i == 0);
      if (cam_ready) i++;
      else lows++;
      tick;
      guard++;
      if (guard > 200) begin
        checks++; failures++;
        $display("FAIL cam_timeout accepted=%0d required=%0d", i, npix);
        break;
      end
    end
    cam_valid = 1'b0; cam_sof = 1'b0;
  endtask

  task automatic check_log(input string name, input logic [7:0] first);
    logic [15:0] exp_d;
    checks++;
    if (log_addr.size() !== 8) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=8", name, log_addr.size());
    end
    for (int k = 0; k < 8; k++) begin
      if (k < log_addr.size()) begin
        exp_d = {first + 8'(2 * k + 1), first + 8'(2 * k)};
        checks++;
        if (log_addr[k] !== WB + 4'(k) || log_data[k] !== exp_d) begin
          failures++;
          $display("FAIL %s_word%0d got=%0h@%0h exp=%0h@%0h", name, k, log_data[k], log_addr[k], exp_d, WB + 4'(k));
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    checks++;
    if (cam_ready !== 1'b0 || disp_data !== 8'h00 || underrun !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 4'd0) begin
      failures++;
      $display("FAIL reset_values got rdy=%b dd=%0h un=%b we=%b a=%0h exp all 0", cam_ready, disp_data, underrun, mem_we, mem_addr);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (cam_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b exp=1", cam_ready);
    end
  endtask

  task automatic test_write_pairing;
    int lows;
    do_reset;
    cam_frame(8'h01, 16, lows);
    for (int k = 0; k < 4; k++) begin
      if (!cam_ready) lows++;
      tick;
    end
    checks++;
    if (lows !== 8) begin
      failures++;
      $display("FAIL ready_low_cycles got=%0d exp=8", lows);
    end
    check_log("pairing", 8'h01);
  endtask

  task automatic test_prime_read;
    do_reset;
    preload(4'd0, 8'h00);
    disp_sof = 1'b1; tick; disp_sof = 1'b0;
    repeat (6) tick;
    for (int k = 0; k < 16; k++) begin
      disp_req = 1'b1;
      tick;
      checks++;
      if (disp_data !== 8'(k)) begin
        failures++;
        $display("FAIL read_pix%0d got=%0h exp=%0h", k, disp_data, 8'(k));
      end
    end
    disp_req = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL read_underrun got=%b exp=0", underrun);
    end
  endtask

  task automatic test_contention;
    int lows;
    do_reset;
    preload(4'd0, 8'h00);
    fork
      cam_frame(8'h80, 16, lows);
      begin
        disp_sof = 1'b1; tick; disp_sof = 1'b0;
        repeat (6) tick;
        disp_req = 1'b1;
        repeat (16) tick;
        disp_req = 1'b0;
      end
    join
    repeat (6) tick;
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL contention_underrun got=%b exp=0", underrun);
    end
    check_log("contention", 8'h80);
  endtask

  task automatic test_underrun;
    disp_sof = 1'b1; tick; disp_sof = 1'b0;
    disp_req = 1'b1; tick; disp_req = 1'b0;
    checks++;
    if (disp_data !== 8'h00 || underrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun_flag got=%0h/%b exp=0/1", disp_data, underrun);
    end
    repeat (6) tick;
    checks++;
    if (underrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun_sticky got=%b exp=1", underrun);
    end
    disp_sof = 1'b1; tick; disp_sof = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_clear got=%b exp=0", underrun);
    end
    repeat (6) tick;
    for (int k = 0; k < 3; k++) begin
      disp_req = 1'b1; tick;
      checks++;
      if (disp_data !== 8'h80 + 8'(k)) begin
        failures++;
        $display("FAIL refill_pix%0d got=%0h exp=%0h", k, disp_data, 8'h80 + 8'(k));
      end
    end
    disp_sof = 1'b1; disp_req = 1'b1; tick;
    disp_sof = 1'b0; disp_req = 1'b0;
    checks++;
    if (disp_data !== 8'h00 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL sof_wins got=%0h/%b exp=0/0", disp_data, underrun);
    end
  endtask

  task automatic test_reset_midframe;
    do_reset;
    disp_sof = 1'b1; tick; disp_sof = 1'b0;
    tick; tick;
    cam_valid = 1'b1; cam_sof = 1'b1; cam_data = 8'h55; tick;
    cam_sof = 1'b0; cam_data = 8'h66; tick;
    cam_valid = 1'b0; reset = 1'b1; tick;
    checks++;
    if (mem_we !== 1'b0 || cam_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs got we=%b rdy=%b exp 0/0", mem_we, cam_ready);
    end
    reset = 1'b0;
    repeat (6) tick;
    checks++;
    if (log_addr.size() !== 0) begin
      failures++;
      $display("FAIL midreset_stale_write got=%0d writes exp=0", log_addr.size());
    end
    disp_req = 1'b1; tick; disp_req = 1'b0;
    checks++;
    if (underrun !== 1'b1 || disp_data !== 8'h00) begin
      failures++;
      $display("FAIL midreset_fifo_empty got=%b/%0h exp=1/0", underrun, disp_data);
    end
  endtask

`ifdef FB_DOUBLE_BUFFER_EN
  task automatic test_double_buffer;
    int lows;
    do_reset;
    cam_frame(8'h40, 16, lows);
    repeat (4) tick;
    check_log("bankA", 8'h40);
    disp_sof = 1'b1; tick; disp_sof = 1'b0;
    tick;
    checks++;
    if (mem_addr !== 4'd8) begin
      failures++;
      $display("FAIL db_read_addr got=%0h exp=8", mem_addr);
    end
    repeat (4) tick;
    disp_req = 1'b1; tick; disp_req = 1'b0;
    checks++;
    if (disp_data !== 8'h40) begin
      failures++;
      $display("FAIL db_read_pix got=%0h exp=40", disp_data);
    end
    log_clr = 1'b1; tick; log_clr = 1'b0;
    cam_frame(8'h60, 2, lows);
    repeat (4) tick;
    checks++;
    if (log_addr.size() !== 1 || log_addr[0] !== 4'd0) begin
      failures++;
      $display("FAIL db_next_bank got=%0d writes first@%0h exp=1@0", log_addr.size(), log_addr[0]);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_write_pairing;
    test_prime_read;
    test_contention;
    test_underrun;
    test_reset_midframe;
`ifdef FB_DOUBLE_BUFFER_EN
    test_double_buffer;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
